// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
// Used by arm_mc_controller (optional perf counters: ARM_MC_PERFCNT_EN) and arm_cond_unit.
package arm_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ORR = 2'b11
   } alu_ctl_e;

   typedef enum logic [3:0] {
      C_EQ = 4'd0,  C_NE = 4'd1,  C_CS = 4'd2,  C_CC = 4'd3,
      C_MI = 4'd4,  C_PL = 4'd5,  C_VS = 4'd6,  C_VC = 4'd7,
      C_HI = 4'd8,  C_LS = 4'd9,  C_GE = 4'd10, C_LT = 4'd11,
      C_GT = 4'd12, C_LE = 4'd13, C_AL = 4'd14, C_NV = 4'd15
   } cond_e;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCB_WD   = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_8  = 2'b00;
   localparam logic [1:0] IMM_12 = 2'b01;
   localparam logic [1:0] IMM_24 = 2'b10;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // flags are ordered {N,Z,C,V}
   function automatic logic cond_holds(input cond_e c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         C_EQ:    cond_holds = z;
         C_NE:    cond_holds = ~z;
         C_CS:    cond_holds = cy;
         C_CC:    cond_holds = ~cy;
         C_MI:    cond_holds = n;
         C_PL:    cond_holds = ~n;
         C_VS:    cond_holds = v;
         C_VC:    cond_holds = ~v;
         C_HI:    cond_holds = cy & ~z;
         C_LS:    cond_holds = ~cy | z;
         C_GE:    cond_holds = (n == v);
         C_LT:    cond_holds = (n != v);
         C_GT:    cond_holds = ~z & (n == v);
         C_LE:    cond_holds = z | (n != v);
         C_AL:    cond_holds = 1'b1;
         default: cond_holds = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flag register and condition-code evaluation for the multicycle controller.
// The condition outcome is captured once per instruction and gates every later write.
module arm_cond_unit
   import arm_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] i_cond,
   input  logic [3:0] i_alu_flags,
   input  logic       i_cond_latch,
   input  logic       i_flag_we,
   output logic       o_cond_ex,
   output logic [3:0] o_flags
);

   logic [3:0] r_flags;
   logic       r_cond_ex;

   // flag updates use the condition captured for the current instruction
   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags   <= 4'b0000;
         r_cond_ex <= 1'b0;
      end else begin
         if (i_cond_latch)
            r_cond_ex <= cond_holds(cond_e'(i_cond), r_flags);
         if (i_flag_we && r_cond_ex)
            r_flags <= i_alu_flags;
      end
   end

   assign o_cond_ex = r_cond_ex;
   assign o_flags   = r_flags;

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control FSM and instruction decode.
// Optional cycle/instruction counters are built when ARM_MC_PERFCNT_EN is defined.
module arm_mc_controller
   import arm_mc_pkg::*;
`ifdef ARM_MC_PERFCNT_EN
#(
   parameter int CNT_W = 32
)
`endif
(
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] Instr,
   input  logic [3:0]  ALUFlags,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ALUControl,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic        RegWrite,
   output logic [1:0]  RegSrc
`ifdef ARM_MC_PERFCNT_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
`endif
);

   state_e     r_state;
   state_e     w_next;
   logic [1:0] w_op;
   logic       w_i, w_s_l, w_rd_pc;
   logic [3:0] w_cmd;
   alu_ctl_e   w_alu_ctl;
   logic       w_cmd_ok;
   logic       w_cond_ex;
   logic [3:0] w_flags_unused;
   logic       w_unused_bits;
   logic       w_pc_we, w_mem_we, w_ir_we, w_reg_we;
   logic       w_flag_we;

   assign w_op    = Instr[15:14];
   assign w_i     = Instr[13];
   assign w_cmd   = Instr[12:9];
   assign w_s_l   = Instr[8];
   assign w_rd_pc = (Instr[7:4] == 4'hF);
   assign w_unused_bits = ^Instr[3:0];

   assign w_flag_we = ((r_state == S_EXECR) || (r_state == S_EXECI)) && w_s_l;

   arm_cond_unit u_cond (
      .clk          (clk),
      .reset        (reset),
      .i_cond       (Instr[19:16]),
      .i_alu_flags  (ALUFlags),
      .i_cond_latch (r_state == S_DECODE),
      .i_flag_we    (w_flag_we),
      .o_cond_ex    (w_cond_ex),
      .o_flags      (w_flags_unused)
   );

   // unsupported data-processing commands still execute as ADD but never write back
   always_comb begin
      w_alu_ctl = ALU_ADD;
      w_cmd_ok  = 1'b1;
      case (w_cmd)
         4'b0100: w_alu_ctl = ALU_ADD;
         4'b0010: w_alu_ctl = ALU_SUB;
         4'b0000: w_alu_ctl = ALU_AND;
         4'b1100: w_alu_ctl = ALU_ORR;
         default: begin
            w_alu_ctl = ALU_ADD;
            w_cmd_ok  = 1'b0;
         end
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_FETCH;
      else
         r_state <= w_next;
   end

   // next state and datapath controls
   always_comb begin
      w_next     = r_state;
      w_pc_we    = 1'b0;
      w_mem_we   = 1'b0;
      w_ir_we    = 1'b0;
      w_reg_we   = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUControl = ALU_ADD;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_WD;
      ImmSrc     = IMM_8;
      RegSrc     = {(w_op == OP_MEM) && !w_s_l, (w_op == OP_BR)};
      case (r_state)
         S_FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            RegSrc    = 2'b00;
            w_ir_we   = mem_ready;
            w_pc_we   = mem_ready;
            w_next    = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            case (w_op)
               OP_MEM:  w_next = S_MEMADR;
               OP_DP:   w_next = w_i ? S_EXECI : S_EXECR;
               OP_BR:   w_next = S_BRANCH;
               default: w_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_12;
            w_next  = w_s_l ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            AdrSrc = 1'b1;
            w_next = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            w_reg_we  = w_cond_ex && !w_rd_pc;
            w_pc_we   = w_cond_ex && w_rd_pc;
            w_next    = S_FETCH;
         end
         S_MEMWR: begin
            AdrSrc   = 1'b1;
            w_mem_we = w_cond_ex;
            w_next   = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXECR, S_EXECI: begin
            ALUSrcB    = (r_state == S_EXECI) ? SRCB_IMM : SRCB_WD;
            ImmSrc     = IMM_8;
            ALUControl = w_alu_ctl;
            w_next     = S_ALUWB;
         end
         S_ALUWB: begin
            ResultSrc = RES_ALUOUT;
            w_reg_we  = w_cond_ex && w_cmd_ok && !w_rd_pc;
            w_pc_we   = w_cond_ex && w_cmd_ok && w_rd_pc;
            w_next    = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcB   = SRCB_IMM;
            ImmSrc    = IMM_24;
            RegSrc    = 2'b01;
            ResultSrc = RES_ALURESULT;
            w_pc_we   = w_cond_ex;
            w_next    = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // reset drops any write strobe that would otherwise fire this cycle
   assign PCWrite  = w_pc_we  && !reset;
   assign MemWrite = w_mem_we && !reset;
   assign IRWrite  = w_ir_we  && !reset;
   assign RegWrite = w_reg_we && !reset;

`ifdef ARM_MC_PERFCNT_EN
   // free-running performance counters, wrapping naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if ((r_state == S_FETCH) && mem_ready)
            instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
